// File: rtl/input_conditioner_pkg.sv
// Shared constants for the board input conditioner: clock rate, default
// debounce window, channel index map and the per-edge debounce decision type.
package input_conditioner_pkg;

  localparam int CLK_HZ                  = 100_000_000;
  localparam int DEBOUNCE_MS             = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEFAULT_N_CH            = 4;

  // Board wiring: which conditioner channel each switch/button lands on.
  localparam int SW0       = 0;
  localparam int SW1       = 1;
  localparam int BTN_PAUSE = 2;
  localparam int BTN_RST   = 3;

  typedef enum logic [1:0] {
    DB_HOLD,
    DB_COUNT,
    DB_COMMIT
  } db_action_e;

  // A window of one cycle still needs a one-bit counter to keep widths legal.
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles <= 1) ? 1 : $clog2(debounce_cycles);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned input bit: two-flop synchroniser, stability counter,
// registered edge pulses and a press-toggled latch.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic tog
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  db_action_e       action;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Any sample agreeing with the current level throws away the partial count.
  always_comb begin
    action = DB_HOLD;
    if (s2 != level) begin
      action = (cnt == CNT_LAST) ? DB_COMMIT : DB_COUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      unique case (action)
        DB_COUNT: cnt <= cnt + CNT_W'(1);
        default:  cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      tog   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (action == DB_COMMIT) begin
        level <= s2;
        rise  <= s2;
        fall  <= ~s2;
        tog   <= tog ^ s2;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel switch/button conditioner: fixes per-channel polarity and
// feeds each bit through its own independent debounce channel.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int              N_CH            = DEFAULT_N_CH,
  parameter int              DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int              CNT_W           = cnt_width(DEBOUNCE_CYCLES),
  parameter logic [N_CH-1:0] INVERT_MASK     = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] tog
);

  // Active-low pins are flipped before synchronising so reset (0) means idle.
  logic [N_CH-1:0] active_high;

  assign active_high = raw ^ INVERT_MASK;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (active_high[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .tog  (tog[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: fixed vector table, directed
// corner sequences, and random stimulus against a sliding-window model.
module tb_input_conditioner;

  localparam int         N_CH = 4;
  localparam int         DC   = 4;
  localparam logic [3:0] INV  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw;
  logic [3:0] level, rise, fall, tog;

  int tests = 0;
  int failures = 0;

  input_conditioner #(
    .N_CH           (N_CH),
    .DEBOUNCE_CYCLES(DC),
    .INVERT_MASK    (INV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw),
    .level(level),
    .rise (rise),
    .fall (fall),
    .tog  (tog)
  );

  always #5 clk = ~clk;

  // Reference: a change is accepted once the last DC synchronised samples
  // all disagree with the current level.
  logic [3:0] m_s1, m_s2, m_level, m_rise, m_fall, m_tog;
  bit         win_q[N_CH][$];

  int edge_cnt;
  int rise_cnt[N_CH];
  int fall_cnt[N_CH];
  int rise_edge[N_CH];

  typedef struct {
    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] tog;
  } vec_t;

  vec_t tbl[16];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_tog = '0;
    for (int c = 0; c < N_CH; c++) win_q[c].delete();
  endtask

  task automatic model_edge(input logic [3:0] r);
    bit all_differ;
    for (int c = 0; c < N_CH; c++) begin
      win_q[c].push_back(m_s2[c]);
      if (win_q[c].size() > DC) void'(win_q[c].pop_front());
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      all_differ = (win_q[c].size() == DC);
      foreach (win_q[c][k]) if (win_q[c][k] == m_level[c]) all_differ = 1'b0;
      if (all_differ) begin
        m_level[c] = ~m_level[c];
        if (m_level[c]) begin
          m_rise[c] = 1'b1;
          m_tog[c]  = ~m_tog[c];
        end else begin
          m_fall[c] = 1'b1;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = r ^ INV;
  endtask

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, edge_cnt, act, exp);
    end
  endtask

  task automatic cmpInt(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, "_level"}, level, m_level);
    cmp({tag, "_rise"},  rise,  m_rise);
    cmp({tag, "_fall"},  fall,  m_fall);
    cmp({tag, "_tog"},   tog,   m_tog);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic [3:0] r);
    raw = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    edge_cnt++;
    for (int c = 0; c < N_CH; c++) begin
      if (rise[c]) begin
        rise_cnt[c]++;
        rise_edge[c] = edge_cnt;
      end
      if (fall[c]) fall_cnt[c]++;
    end
  endtask

  task automatic tick(input logic [3:0] r, input string tag);
    applyStimulus(r);
    checkOutput(tag);
  endtask

  task automatic clear_tally();
    edge_cnt = 0;
    for (int c = 0; c < N_CH; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; rise_edge[c] = -1;
    end
  endtask

  // Asserted between edges so the clear must be asynchronous to be seen.
  task automatic doReset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 checkOutput(tag);
    cmp({tag, "_zero"}, level | rise | fall | tog, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_tally();
  endtask

  initial begin
    logic [3:0] cur;
    int         hold_left[N_CH];

    tbl[0]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 2; i < 7; i++) tbl[i] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    tbl[8]  = '{4'b1001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    for (int i = 9; i < 12; i++) tbl[i] = '{4'b1011, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    for (int i = 12; i < 16; i++) tbl[i] = '{4'b1001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};

    raw   = 4'b1000;
    rst_n = 1'b0;
    model_reset();
    clear_tally();
    @(negedge clk);
    doReset("por");

    // Press on ch0 (commits exactly DC+1 edges later), then a too-short pulse on ch1.
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].raw);
      cmp("tbl_level", level, tbl[i].level);
      cmp("tbl_rise",  rise,  tbl[i].rise);
      cmp("tbl_fall",  fall,  tbl[i].fall);
      cmp("tbl_tog",   tog,   tbl[i].tog);
    end

    // Bouncing ch2: only the final stable run counts.
    doReset("rst_bounce");
    begin
      logic [4:0] bounce;
      bounce = 5'b10101;
      for (int i = 0; i < 15; i++)
        tick({1'b1, (i < 5) ? bounce[i] : 1'b1, 2'b00}, "bounce");
    end
    cmpInt("bounce_rise_cnt", rise_cnt[2], 1);
    cmpInt("bounce_rise_edge", rise_edge[2], 10);
    cmpInt("bounce_fall_cnt", fall_cnt[2], 0);

    // Active-low ch3: idle high, pulled low, released.
    doReset("rst_inv");
    repeat (3) tick(4'b1000, "inv_idle");
    cmpInt("inv_idle_level", int'(level[3]), 0);
    repeat (10) tick(4'b0000, "inv_press");
    cmpInt("inv_pressed_level", int'(level[3]), 1);
    repeat (10) tick(4'b1000, "inv_release");
    cmpInt("inv_rise_cnt", rise_cnt[3], 1);
    cmpInt("inv_fall_cnt", fall_cnt[3], 1);
    cmpInt("inv_tog", int'(tog[3]), 1);
    cmpInt("inv_final_level", int'(level[3]), 0);

    // Three full press/release cycles on ch0.
    doReset("rst_press3");
    for (int p = 0; p < 3; p++) begin
      repeat (8) tick(4'b1001, "press3_hi");
      repeat (8) tick(4'b1000, "press3_lo");
    end
    cmpInt("press3_rise_cnt", rise_cnt[0], 3);
    cmpInt("press3_fall_cnt", fall_cnt[0], 3);
    cmpInt("press3_tog", int'(tog[0]), 1);

    // Reset while ch0 is high and ch1 is mid-count; both held through release.
    doReset("rst_mid");
    repeat (8) tick(4'b1001, "mid_hold");
    cmpInt("mid_level0", int'(level[0]), 1);
    repeat (2) tick(4'b1011, "mid_count");
    doReset("rst_async");
    repeat (8) tick(4'b1011, "post_rst");
    cmpInt("post_rst_rise_edge0", rise_edge[0], DC + 2);
    cmpInt("post_rst_rise_edge1", rise_edge[1], DC + 2);
    cmpInt("post_rst_rise_cnt0", rise_cnt[0], 1);
    cmpInt("post_rst_rise_cnt1", rise_cnt[1], 1);

    // Random hold times on every channel, with one reset part-way through.
    doReset("rst_rand");
    cur = 4'b1000;
    for (int c = 0; c < N_CH; c++) hold_left[c] = 0;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) doReset("rst_rand_mid");
      for (int c = 0; c < N_CH; c++) begin
        if (hold_left[c] == 0) begin
          cur[c]       = 1'($urandom_range(0, 1));
          hold_left[c] = $urandom_range(1, 9);
        end
        hold_left[c]--;
      end
      tick(cur, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
